// File: rtl/sr_bank_ctrl.sv
// Round-robin controller sharing one bank of clocked SR flip-flops among NREQ requesters.
// Each operation pulses one s or r bit, checks the q feedback and returns done/err.
module sr_bank_ctrl #(
    parameter int NREQ  = 4,
    parameter int NBITS = 8,
    parameter int IDX_W = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        op,
    input  logic [NREQ*IDX_W-1:0]  idx,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        done,
    output logic                   err,
    output logic                   busy,
    output logic [NBITS-1:0]       s,
    output logic [NBITS-1:0]       r,
    input  logic [NBITS-1:0]       q_fb
);

    localparam int CUR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, ACK} state_t;

    state_t             state, state_nx;
    logic [CUR_W-1:0]   rr, rr_nx;
    logic [CUR_W-1:0]   cur, cur_nx;
    logic               cap_op, cap_op_nx;
    logic [IDX_W-1:0]   cap_idx, cap_idx_nx;
    logic               bad, bad_nx;

    logic [NREQ-1:0]    gnt_nx, done_nx;
    logic               err_nx, busy_nx;
    logic [NBITS-1:0]   s_nx, r_nx;

    // Arbiter scan signals
    logic               found;
    logic [CUR_W-1:0]   win;
    logic [CUR_W-1:0]   cand;
    int                 sum;

    logic [IDX_W-1:0]   win_idx;
    logic [NBITS-1:0]   drive_mask;
    logic [NBITS-1:0]   cap_mask;
    logic               q_sel;

    // NOTE: every variable driven in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred; blocking '=' is used
    // here, non-blocking '<=' only in the clocked process.
    always_comb begin
        found = 1'b0;
        win   = rr;
        cand  = rr;
        sum   = 0;
        for (int k = 0; k < NREQ; k++) begin
            sum = int'(rr) + k;
            if (sum >= NREQ) sum = sum - NREQ;
            cand = CUR_W'(sum);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // An out-of-range index shifts the single 1 out of the mask, leaving it zero.
    assign win_idx    = idx[win*IDX_W +: IDX_W];
    assign drive_mask = NBITS'(1) << win_idx;
    assign cap_mask   = NBITS'(1) << cap_idx;
    assign q_sel      = |(q_fb & cap_mask);

    always_comb begin
        state_nx   = state;
        rr_nx      = rr;
        cur_nx     = cur;
        cap_op_nx  = cap_op;
        cap_idx_nx = cap_idx;
        bad_nx     = bad;
        gnt_nx     = '0;
        done_nx    = '0;
        err_nx     = 1'b0;
        s_nx       = '0;
        r_nx       = '0;
        busy_nx    = 1'b1;

        case (state)
            IDLE: begin
                busy_nx = 1'b0;
                if (found) begin
                    state_nx   = DRIVE;
                    busy_nx    = 1'b1;
                    cur_nx     = win;
                    cap_op_nx  = op[win];
                    cap_idx_nx = win_idx;
                    bad_nx     = (drive_mask == '0);
                    gnt_nx     = NREQ'(1) << win;
                    s_nx       = op[win] ? drive_mask : '0;
                    r_nx       = op[win] ? '0 : drive_mask;
                end
            end
            DRIVE: begin
                state_nx = SETTLE;
            end
            SETTLE: begin
                state_nx = ACK;
                done_nx  = NREQ'(1) << cur;
                err_nx   = bad | (q_sel != cap_op);
            end
            ACK: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
                rr_nx    = (cur == CUR_W'(NREQ - 1)) ? '0 : cur + 1'b1;
            end
            default: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rr      <= '0;
            cur     <= '0;
            cap_op  <= 1'b0;
            cap_idx <= '0;
            bad     <= 1'b0;
            gnt     <= '0;
            done    <= '0;
            err     <= 1'b0;
            busy    <= 1'b0;
            s       <= '0;
            r       <= '0;
        end else begin
            state   <= state_nx;
            rr      <= rr_nx;
            cur     <= cur_nx;
            cap_op  <= cap_op_nx;
            cap_idx <= cap_idx_nx;
            bad     <= bad_nx;
            gnt     <= gnt_nx;
            done    <= done_nx;
            err     <= err_nx;
            busy    <= busy_nx;
            s       <= s_nx;
            r       <= r_nx;
        end
    end

endmodule

// File: tb/tb_sr_bank_ctrl.sv
// Directed and randomized bench for sr_bank_ctrl with a behavioural SR bank and a
// transaction-level reference (rr pointer, flag image, expected err).
module tb_sr_bank_ctrl;

    localparam int NREQ  = 4;
    localparam int NBITS = 6;
    localparam int IDX_W = 3;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req, op;
    logic [NREQ*IDX_W-1:0] idx;
    logic [NREQ-1:0]       gnt, done;
    logic                  err, busy;
    logic [NBITS-1:0]      s, r, q_fb;

    sr_bank_ctrl #(.NREQ(NREQ), .NBITS(NBITS), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op(op), .idx(idx),
        .gnt(gnt), .done(done), .err(err), .busy(busy),
        .s(s), .r(r), .q_fb(q_fb)
    );

    always #5 clk = ~clk;

    // SR flip-flop bank; bit 1 can be made to ignore its set input.
    logic [NBITS-1:0] bank = '0;
    logic             stuck1 = 1'b0;
    always @(posedge clk) begin
        for (int i = 0; i < NBITS; i++) begin
            if (s[i] && !(stuck1 && i == 1)) bank[i] <= 1'b1;
            else if (r[i])                   bank[i] <= 1'b0;
        end
    end
    assign q_fb = bank;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) check("s_and_r_exclusive", 32'(s & r), 32'd0);

    // Reference state
    int               ptr = 0;
    logic [NBITS-1:0] exp_flags = '0;
    int               last_gnt_cyc = 0;

    function automatic int pick(input logic [NREQ-1:0] rv, input int p);
        for (int k = 0; k < NREQ; k++)
            if (rv[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    // One complete operation: DRIVE, SETTLE, ACK, IDLE, checked cycle by cycle.
    task automatic run_one(output int w);
        logic             o, bad_i, q_after, e_err;
        logic [IDX_W-1:0] ix;
        logic [NBITS-1:0] m;
        w = pick(req, ptr);
        if (w < 0) begin
            check("no_request_pending", 32'd0, 32'd1);
            return;
        end
        o       = op[w];
        ix      = idx[w*IDX_W +: IDX_W];
        bad_i   = (int'(ix) >= NBITS);
        m       = bad_i ? '0 : NBITS'(1 << ix);
        q_after = bad_i ? 1'b0 : ((stuck1 && ix == 1 && o) ? exp_flags[ix] : o);
        e_err   = bad_i || (q_after != o);

        @(posedge clk); #1;
        last_gnt_cyc = cyc;
        check("drive_gnt",  32'(gnt), 32'(1 << w));
        check("drive_s",    32'(s), 32'(o ? m : '0));
        check("drive_r",    32'(r), 32'(o ? '0 : m));
        check("drive_busy", 32'(busy), 32'd1);
        check("drive_done", 32'(done), 32'd0);
        req[w] = 1'b0;
        if (!bad_i) exp_flags[ix] = q_after;

        @(posedge clk); #1;
        check("settle_gnt",  32'(gnt), 32'd0);
        check("settle_sr",   32'({s, r}), 32'd0);
        check("settle_busy", 32'(busy), 32'd1);
        check("settle_done", 32'(done), 32'd0);

        @(posedge clk); #1;
        check("ack_done", 32'(done), 32'(1 << w));
        check("ack_err",  32'(err), 32'(e_err));
        check("ack_busy", 32'(busy), 32'd1);
        check("ack_bank", 32'(q_fb), 32'(exp_flags));
        ptr = (w + 1) % NREQ;

        @(posedge clk); #1;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_err",  32'(err), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        int gc[NREQ];
        int guard;
        rst_n = 1'b0; req = '0; op = '0; idx = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_gnt",  32'(gnt), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_err",  32'(err), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_s",    32'(s), 32'd0);
        check("reset_r",    32'(r), 32'd0);

        // Single set of bit 5 by requester 2, presented at reset release.
        req = 4'b0100; op[2] = 1'b1; idx[2*IDX_W +: IDX_W] = 3'd5;
        rst_n = 1'b1;
        run_one(w);
        check("t1_winner", 32'(w), 32'd2);
        check("t1_q5", 32'(q_fb[5]), 32'd1);

        // Re-reset so the pointer is 0, then four simultaneous sets.
        rst_n = 1'b0; #1; rst_n = 1'b1; ptr = 0;
        req = 4'b1111; op = 4'b1111; idx = {3'd3, 3'd2, 3'd1, 3'd0};
        for (int i = 0; i < NREQ; i++) begin
            run_one(w);
            gc[i] = last_gnt_cyc;
            check("t2_order", 32'(w), 32'(i));
        end
        for (int i = 1; i < NREQ; i++) check("t2_spacing", 32'(gc[i] - gc[i-1]), 32'd4);
        req = 4'b0011;
        run_one(w);
        check("t2_wrap_winner", 32'(w), 32'd0);
        run_one(w);
        check("t2_loser_next", 32'(w), 32'd1);

        // Set then clear bit 3 from different requesters.
        req = 4'b0100; op[2] = 1'b1; idx[2*IDX_W +: IDX_W] = 3'd3;
        run_one(w);
        req = 4'b1000; op[3] = 1'b0; idx[3*IDX_W +: IDX_W] = 3'd3;
        run_one(w);
        check("t3_final_q3", 32'(q_fb[3]), 32'd0);

        // Out-of-range index.
        req = 4'b0001; op[0] = 1'b1; idx[0 +: IDX_W] = 3'd7;
        run_one(w);
        check("t4_winner", 32'(w), 32'd0);

        // Set on a bit that ignores s must report err.
        req = 4'b0010; op[1] = 1'b0; idx[1*IDX_W +: IDX_W] = 3'd1;
        run_one(w);
        stuck1 = 1'b1;
        req = 4'b0100; op[2] = 1'b1; idx[2*IDX_W +: IDX_W] = 3'd1;
        run_one(w);
        stuck1 = 1'b0;

        // Abort during SETTLE; pointer (3 here) must return to 0.
        check("t6_ptr_before", 32'(ptr), 32'd3);
        req = 4'b1000; op[3] = 1'b1; idx[3*IDX_W +: IDX_W] = 3'd4;
        @(posedge clk); #1;
        check("t6_drive_gnt", 32'(gnt), 32'b1000);
        req = '0; exp_flags[4] = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        check("t6_abort_outs", 32'({gnt, done, err, busy, s, r}), 32'd0);
        @(posedge clk); #1;
        check("t6_no_done", 32'(done), 32'd0);
        check("t6_bank_kept", 32'(q_fb), 32'(exp_flags));
        ptr = 0;
        req = 4'b1010; op = 4'b1010; idx = {3'd2, 3'd0, 3'd0, 3'd0};
        rst_n = 1'b1;
        run_one(w);
        check("t6_after_reset_winner", 32'(w), 32'd1);
        run_one(w);
        check("t6_second_winner", 32'(w), 32'd3);

        // Randomized batches served to completion.
        repeat (15) begin
            req = 4'($urandom_range(1, 15));
            op  = 4'($urandom);
            idx = 12'($urandom);
            guard = 0;
            while (req != '0 && guard < NREQ) begin
                run_one(w);
                guard++;
            end
            check("rand_all_served", 32'(req), 32'd0);
        end

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sr_bank_ctrl.md
# sr_bank_ctrl

Controller that shares one bank of NBITS clocked SR flip-flops (sr_ff instances) among NREQ requesters. Each requester asks to set or clear one flag bit. The block arbitrates round-robin and drives single-cycle s/r pulses into the bank, never asserting s and r together on any bit. It then checks the bank's q feedback and returns a per-requester done/err completion. It sits between software-visible flag clients and the sr_ff bank, and is the only driver of the bank's s and r inputs.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- NBITS, 8, number of flags in the bank
- IDX_W, 3, width of a flag index; must satisfy 2**IDX_W >= NBITS

Ports:
- clk  in  1  rising-edge clock; the same clock the sr_ff bank uses
- rst_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester request level
- op  in  NREQ  per-requester operation: 1 = set, 0 = reset
- idx  in  NREQ*IDX_W  per-requester flag index; requester i occupies bits [i*IDX_W +: IDX_W]
- gnt  out  NREQ  one-hot grant pulse, one cycle
- done  out  NREQ  one-hot completion pulse, one cycle
- err  out  1  valid with done; 1 = bad index or q mismatch
- busy  out  1  high whenever the FSM is not in IDLE
- s  out  NBITS  set pulses to the bank
- r  out  NBITS  reset pulses to the bank
- q_fb  in  NBITS  q outputs of the bank

## Operation
- All outputs are registered. Reset values: gnt=0, done=0, err=0, busy=0, s=0, r=0, state=IDLE, rr pointer=0 (requester 0 has highest priority).
- FSM states: IDLE, DRIVE, SETTLE, ACK.
- IDLE, when any req bit is high:
  - Pick the first requesting index at or after the rr pointer, wrapping modulo NREQ.
  - Capture its op and idx, and its number as cur.
  - Go to DRIVE.
- DRIVE (one cycle):
  - gnt[cur] = 1.
  - If idx < NBITS: s[idx] = op and r[idx] = ~op. All other s and r bits are 0.
  - If idx >= NBITS: s = r = 0 and a bad flag is latched.
  - Go to SETTLE.
- SETTLE (one cycle):
  - s = r = 0.
  - At the closing edge, compare q_fb[idx] with op. A mismatch, or the bad flag, sets err_pending.
  - Go to ACK.
- ACK (one cycle):
  - done[cur] = 1 and err = err_pending.
  - rr pointer = (cur+1) mod NREQ.
  - Return to IDLE.
- Requester protocol:
  - Hold req, op and idx stable until gnt is seen.
  - req must drop in the cycle after gnt, unless a new operation is intended.
  - A req still high in IDLE after ACK is treated as a new request.
- Requests that arrive while busy are ignored until IDLE. No queueing.
- s & r == 0 on every bit in every cycle. This is an invariant.
- The bank is touched only in DRIVE, and only on one bit.

## Timing
- Let edge E be the edge at which IDLE sees req. Then:
  - Cycle after E: DRIVE. gnt and s/r are high.
  - Next cycle: SETTLE.
  - Next cycle: ACK. done and err are high.
  - Next cycle: IDLE.
- Request to done latency: 3 cycles. Throughput: one operation per 4 cycles. Back-to-back operations reach DRIVE again on the cycle after ACK+1.
- busy is high in DRIVE, SETTLE and ACK.
- Boundary cases:
  - Simultaneous requests: winner is determined by the rr pointer only. Losers wait.
  - Pointer wrap: after cur = NREQ-1 the pointer becomes 0.
  - An op equal to the current flag value (for example, setting an already-set bit) still pulses and completes with err=0.
  - An idx >= NBITS produces no s/r activity and completes with done + err=1.
- Reset mid-operation: s, r, gnt and done clear immediately (asynchronously). No done is issued for the aborted operation, and the pointer returns to 0. Flag state in the bank is whatever the sr_ff holds.
- Deasserting rst_n takes effect at the next clk edge. A req already high is arbitrated on that edge.

## Test plan
- Reset, then req[2]=1, op=1, idx=5: gnt[2] and s=0x20 in cycle 1, r=0; done[2] in cycle 3 with err=0; q_fb[5]=1.
- req=0b1111, all ops set, idx=i: grants in order 0,1,2,3, each 4 cycles apart. Then req[1] and req[0] together: pointer is at 0, so 0 wins.
- Set bit 3, then reset bit 3 from another requester: r=0x08 in the second DRIVE; final q_fb[3]=0; s&r==0 checked every cycle.
- idx=7 with NBITS=6: s=r=0 throughout; done with err=1 at cycle 3.
- Bank model forced to ignore s on bit 1 (q_fb[1] stays 0) while setting bit 1: done with err=1.
- rst_n pulsed low during SETTLE: all outputs 0 immediately, no done; the next request is granted using pointer 0.
